io_bus_multi_copier: RTL
========================

// Module: io_bus_multi_copier
// PURPOSE
//  Free-running I/O-bus transfer engine, next generation of the single-byte read/write copier.
//  Each frame: for each of NCH channels, read one word from port SRC_BASE+k (ior_ strobe), transform it, write it to port DST_BASE+k (iow_ strobe).
//  Drives the shared tri-state data bus, address bus and active-low strobes; frames repeat every PERIOD clocks.
// PARAMETERS
//  DW        8   data bus width
//  AW        2   address bus width
//  NCH       1   channels per frame, 1..2**AW/2
//  SRC_BASE  0   source port address of channel 0
//  DST_BASE  1   destination port address of channel 0 (SRC/DST ranges must not overlap)
//  RD_WS     0   extra ior_ low cycles (wait states), 0..15
//  WR_WS     0   extra iow_ low cycles, 0..15
//  PERIOD    20  frame period in clocks (start to start)
//  XFORM     0   0 = pass-through, 1 = bitwise invert, 2 = add channel index mod 2**DW
// PORTS
//  clock       in    1   system clock, rising edge
//  reset_      in    1   asynchronous active-low reset
//  en          in    1   start new frames while high
//  d_bus       inout DW  shared data bus; driven only while dir=1, else high-Z
//  addr        out   AW  port address
//  ior_        out   1   read strobe, active low
//  iow_        out   1   write strobe, active low
//  busy        out   1   high while a frame is in progress
//  frame_done  out   1   one-clock pulse after last channel released the bus
//  overrun     out   1   sticky: a frame took longer than PERIOD; cleared only by reset
// BEHAVIOUR
//  - Reset (async, immediate): ior_=1, iow_=1, dir=0 (bus high-Z), addr=0, busy=0, frame_done=0, overrun=0, state IDLE, period and channel counters 0.
//  - All outputs registered; change only on rising clock edges (except reset).
//  - States: IDLE, RADDR, RSTB, TURN, WSTB, WHOLD, GAP.
//  - IDLE: en=1 at an edge -> RADDR with ch=0, period count restarts at 0, busy=1.
//  - RADDR (1 cycle): addr=SRC_BASE+ch, ior_=1, dir=0.
//  - RSTB (RD_WS+1 cycles): ior_=0; d_bus sampled into buffer on the edge that returns ior_ to 1.
//  - TURN (1 cycle): addr=DST_BASE+ch, dir=1, d_bus=XFORM(buffer), iow_=1.
//  - WSTB (WR_WS+1 cycles): iow_=0, data held stable.
//  - WHOLD (1 cycle): iow_=1, data still driven; at exit dir=0.
//  - Channel cost = 5+RD_WS+WR_WS clocks; frame length F = NCH*(5+RD_WS+WR_WS).
//  - After WHOLD: ch<NCH-1 -> ch+1, RADDR; else frame_done pulse, busy=0, -> GAP.
//  - GAP: wait until period count = PERIOD-1; then en=1 -> RADDR (new frame), en=0 -> IDLE.
//  - PERIOD <= F: no GAP cycles; overrun set if PERIOD < F; next frame starts immediately.
//  - en deasserted mid-frame: frame completes; no new frame starts.
//  - ior_ and iow_ never low together; dir=1 never overlaps ior_=0 (one-cycle turnaround each way).
//  - XFORM=2: sum truncated to DW bits, wraps (0xFF+1 -> 0x00 for DW=8).
//  - Reset mid-strobe: strobes deassert and bus releases asynchronously; no partial write is retried.
// STRUCTURE
//  - Package io_bus_pkg: state enum, XFORM mode constants, strobe-width helper function.
//  - Sub-module io_strobe_timer: loadable down-counter for RD_WS/WR_WS strobe widths; done flag.
//  - Top: FSM, period counter (clog2(PERIOD) bits, min 1), channel counter, data buffer, tri-state driver.
// TESTING
//  1 Defaults, bus model returns 0xA5 at addr 0 -> ior_ low 1 cycle, addr 1 written 0xA5 by iow_, frame_done at cycle 5, next frame at cycle 20.
//  2 NCH=2, RD_WS=2, WR_WS=1, XFORM=1, ports 0/1 return 0x0F/0xF0 -> ior_ low 3, iow_ low 2, writes 0xF0 to addr 2, 0x0F to addr 3; F=16.
//  3 XFORM=2, NCH=2, source data 0xFF on ch1 -> written value 0x00 (wrap).
//  4 PERIOD=4 with F=5 -> overrun=1 after first frame, frames back-to-back, no GAP.
//  5 en dropped during WSTB -> frame finishes, frame_done pulses, state IDLE, bus high-Z.
//  6 reset_ low during WSTB -> ior_/iow_=1, d_bus high-Z same cycle; after release restarts at channel 0.
//  Checkers throughout: no ior_/iow_ overlap, no bus drive while ior_=0.

Source files
------------

// File: rtl/io_bus_multi_copier_pkg.sv
// Shared types and helpers for the I/O-bus multi-channel copier.
//   state_e      : transfer FSM states
//   XF_*         : data transform modes
//   WS_W         : strobe wait-state counter width
//   strobe_load  : converts a wait-state count to the timer load value
package io_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RADDR,
      ST_RSTB,
      ST_TURN,
      ST_WSTB,
      ST_WHOLD,
      ST_GAP
   } state_e;

   localparam int unsigned XF_PASS = 0;
   localparam int unsigned XF_INV  = 1;
   localparam int unsigned XF_ADD  = 2;

   localparam int unsigned WS_W = 4;

   // A strobe lasts ws+1 cycles: the timer counts ws down to zero.
   function automatic logic [WS_W-1:0] strobe_load(input int unsigned ws);
      return WS_W'(ws);
   endfunction

endpackage

// File: rtl/io_bus_multi_copier_if.sv
// Address and strobe group of the shared I/O bus.
//   addr : port address
//   ior_ : read strobe, active low
//   iow_ : write strobe, active low
interface io_bus_multi_copier_if #(
   parameter int unsigned AW = 2
);
   logic [AW-1:0] addr;
   logic          ior_;
   logic          iow_;

   modport master (output addr, ior_, iow_);
   modport slave  (input  addr, ior_, iow_);
endinterface

// File: rtl/io_bus_multi_copier_strobe_timer.sv
// Loadable down-counter timing strobe widths.
//   clk, rst_n : clock, async active-low reset
//   i_load     : load i_value (takes priority over counting)
//   i_value    : wait-state count
//   o_done_c   : counter has reached zero (combinational)
module io_strobe_timer
   import io_bus_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic [WS_W-1:0] i_value,
   output logic            o_done_c
);

   logic [WS_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               r_cnt <= '0;
      else if (i_load)          r_cnt <= i_value;
      else if (r_cnt != '0)     r_cnt <= r_cnt - WS_W'(1);
   end

   assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/io_bus_multi_copier.sv
// Free-running I/O-bus copier: each frame reads SRC_BASE+k, transforms, writes DST_BASE+k.
//   clock, reset_ : clock, async active-low reset
//   en            : allow new frames to start
//   d_bus         : shared tri-state data bus
//   bus           : addr / ior_ / iow_ group
//   busy          : frame in progress
//   frame_done    : one-cycle pulse after the last channel releases the bus
//   overrun       : sticky, a frame exceeded PERIOD
module io_bus_multi_copier
   import io_bus_pkg::*;
#(
   parameter int unsigned DW       = 8,
   parameter int unsigned AW       = 2,
   parameter int unsigned NCH      = 1,
   parameter int unsigned SRC_BASE = 0,
   parameter int unsigned DST_BASE = 1,
   parameter int unsigned RD_WS    = 0,
   parameter int unsigned WR_WS    = 0,
   parameter int unsigned PERIOD   = 20,
   parameter int unsigned XFORM    = 0
) (
   input  logic                    clock,
   input  logic                    reset_,
   input  logic                    en,
   inout  wire  [DW-1:0]           d_bus,
   io_bus_multi_copier_if.master   bus,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    overrun
);

   localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [PW-1:0]   P_LAST  = PW'(PERIOD - 1);
   localparam logic [CW-1:0]   C_LAST  = CW'(NCH - 1);
   localparam logic [WS_W-1:0] RD_LOAD = strobe_load(RD_WS);
   localparam logic [WS_W-1:0] WR_LOAD = strobe_load(WR_WS);

   state_e          r_state, w_next;
   logic [PW-1:0]   r_period;
   logic [CW-1:0]   r_ch, w_ch_next;
   logic [DW-1:0]   r_wdata;
   logic [AW-1:0]   r_addr, w_addr_next;
   logic            r_dir, r_ior_n, r_iow_n, r_busy, r_frame_done, r_overrun;
   logic            w_start, w_frame_last, w_period_end, w_in_frame, w_tmr_done;

   function automatic logic [DW-1:0] f_xform(input logic [DW-1:0] d, input logic [CW-1:0] ch);
      if (XFORM == XF_INV)      return ~d;
      else if (XFORM == XF_ADD) return d + DW'(ch);
      else                      return d;
   endfunction

   // Timer is loaded in the single-cycle state preceding each strobe.
   io_strobe_timer u_timer (
      .clk      (clock),
      .rst_n    (reset_),
      .i_load   ((r_state == ST_RADDR) || (r_state == ST_TURN)),
      .i_value  ((r_state == ST_RADDR) ? RD_LOAD : WR_LOAD),
      .o_done_c (w_tmr_done)
   );

   assign w_period_end = (r_period == P_LAST);
   assign w_frame_last = (r_state == ST_WHOLD) && (r_ch == C_LAST);
   assign w_in_frame   = (r_state != ST_IDLE) && (r_state != ST_GAP);

   // Next-state, channel and address selection.
   always_comb begin
      w_next      = r_state;
      w_ch_next   = r_ch;
      w_start     = 1'b0;
      w_addr_next = r_addr;
      case (r_state)
         ST_IDLE:  if (en) begin w_next = ST_RADDR; w_start = 1'b1; end
         ST_RADDR: w_next = ST_RSTB;
         ST_RSTB:  if (w_tmr_done) w_next = ST_TURN;
         ST_TURN:  w_next = ST_WSTB;
         ST_WSTB:  if (w_tmr_done) w_next = ST_WHOLD;
         ST_WHOLD: begin
            if (r_ch != C_LAST) begin
               w_next    = ST_RADDR;
               w_ch_next = r_ch + CW'(1);
            end else if (!w_period_end) begin
               w_next = ST_GAP;
            end else if (en) begin
               w_next = ST_RADDR; w_start = 1'b1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (w_period_end) begin
               if (en) begin w_next = ST_RADDR; w_start = 1'b1; end
               else    w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_start) w_ch_next = '0;
      case (w_next)
         ST_RADDR, ST_RSTB:           w_addr_next = AW'(SRC_BASE + 32'(w_ch_next));
         ST_TURN, ST_WSTB, ST_WHOLD:  w_addr_next = AW'(DST_BASE + 32'(w_ch_next));
         default:                     w_addr_next = r_addr;
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // Registered outputs decoded from the next state; period counter saturates at PERIOD-1.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_period     <= '0;
         r_ch         <= '0;
         r_wdata      <= '0;
         r_addr       <= '0;
         r_dir        <= 1'b0;
         r_ior_n      <= 1'b1;
         r_iow_n      <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_start)            r_period <= '0;
         else if (!w_period_end) r_period <= r_period + PW'(1);
         if ((r_state == ST_RSTB) && w_tmr_done) r_wdata <= f_xform(d_bus, r_ch);
         // Still inside the frame at its PERIOD-th cycle means F > PERIOD.
         if (w_in_frame && w_period_end && !w_frame_last) r_overrun <= 1'b1;
         r_ch         <= w_ch_next;
         r_addr       <= w_addr_next;
         r_dir        <= (w_next == ST_TURN) || (w_next == ST_WSTB) || (w_next == ST_WHOLD);
         r_ior_n      <= (w_next != ST_RSTB);
         r_iow_n      <= (w_next != ST_WSTB);
         r_busy       <= (w_next != ST_IDLE) && (w_next != ST_GAP);
         r_frame_done <= w_frame_last;
      end
   end

   assign d_bus      = r_dir ? r_wdata : {DW{1'bz}};
   assign bus.addr   = r_addr;
   assign bus.ior_   = r_ior_n;
   assign bus.iow_   = r_iow_n;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule
